uart_tx: RTL

Serial transmitter for the UART link. It is the counterpart of the receiver: it accepts one parallel byte, then drives a frame on `TX_OUT` with the same rules the receiver expects. The frame is one start bit (0), 8 data bits LSB first, an optional parity bit (even or odd), and one stop bit (1). Each bit lasts `Prescale` clock cycles, so the block runs on the same oversampled clock as the receiver and can be looped back into it directly.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_bit_timer.sv | 48 ++++
 rtl/uart_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity bit from the XOR-reduction of the data word and the parity type.
  function automatic logic parity_bit(input logic xor_all, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~xor_all : xor_all;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..P-1 while enabled and flags the last cycle of each bit.
// A prescale of 0 behaves as 1 so the timer never stalls.
module uart_bit_timer #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_done
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE  = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] ZERO = PRESCALE_WIDTH'(0);

  logic [PRESCALE_WIDTH-1:0] cnt_r;
  logic [PRESCALE_WIDTH-1:0] last_s;

  // Terminal count decode; bit_done is a pure decode of the counter register.
  always_comb begin
    last_s   = ZERO;
    bit_done = 1'b0;
    if (prescale == ZERO) begin
      last_s = ZERO;
    end else begin
      last_s = prescale - ONE;
    end
    if (en && (cnt_r == last_s)) begin
      bit_done = 1'b1;
    end else begin
      bit_done = 1'b0;
    end
  end

  // Cycle counter, held at zero while disabled so every bit starts aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= ZERO;
    end else if (!en) begin
      cnt_r <= ZERO;
    end else if (cnt_r == last_s) begin
      cnt_r <= ZERO;
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit,
// each held for Prescale clock cycles. TX_OUT and Busy are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      Par_En,
  input  logic                      Par_Typ,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  uart_state_e               state_r;
  logic [DATA_WIDTH-1:0]     data_r;
  logic                      par_en_r;
  logic                      par_bit_r;
  logic [PRESCALE_WIDTH-1:0] prescale_r;
  logic [IDX_W-1:0]          idx_r;
  logic [IDX_W-1:0]          idx_next_s;
  logic                      timer_en_s;
  logic                      bit_done_s;

  // Timer runs for the whole frame; next data index for the shift-out.
  always_comb begin
    timer_en_s = 1'b0;
    idx_next_s = idx_r + IDX_ONE;
    if (state_r != IDLE) begin
      timer_en_s = 1'b1;
    end else begin
      timer_en_s = 1'b0;
    end
  end

  uart_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (timer_en_s),
    .prescale (prescale_r),
    .bit_done (bit_done_s)
  );

  // Frame FSM; the line level for the next bit is loaded at each bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      data_r     <= '0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      prescale_r <= '0;
      idx_r      <= '0;
      TX_OUT     <= STOP_BIT;
      Busy       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Data_Valid) begin
            data_r     <= P_DATA;
            par_en_r   <= Par_En;
            par_bit_r  <= parity_bit(^P_DATA, Par_Typ);
            prescale_r <= Prescale;
            idx_r      <= '0;
            state_r    <= START;
            TX_OUT     <= START_BIT;
            Busy       <= 1'b1;
          end
        end
        START: begin
          if (bit_done_s) begin
            state_r <= DATA;
            idx_r   <= '0;
            TX_OUT  <= data_r[0];
          end
        end
        DATA: begin
          if (bit_done_s) begin
            if (idx_r == IDX_LAST) begin
              if (par_en_r) begin
                state_r <= PARITY;
                TX_OUT  <= par_bit_r;
              end else begin
                state_r <= STOP;
                TX_OUT  <= STOP_BIT;
              end
            end else begin
              idx_r  <= idx_next_s;
              TX_OUT <= data_r[idx_next_s];
            end
          end
        end
        PARITY: begin
          if (bit_done_s) begin
            state_r <= STOP;
            TX_OUT  <= STOP_BIT;
          end
        end
        STOP: begin
          if (bit_done_s) begin
            state_r <= IDLE;
            TX_OUT  <= STOP_BIT;
            Busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          TX_OUT  <= STOP_BIT;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
